// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point add controller.
package fp_pkg;

    // Operand classification codes
    typedef enum logic [2:0] {
        ZERO      = 3'b000,
        INF       = 3'b001,
        SUBNORMAL = 3'b010,
        NORMAL    = 3'b011,
        NAN       = 3'b100
    } fp_type_e;

    // Canonical quiet NaN returned for invalid operations and aborts
    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Controller state encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLASSIFY = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT     = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/type_detect.sv
// Classifies an IEEE-754 single operand from its exponent and mantissa fields.
module type_detect
    import fp_pkg::*;
(
    input  logic [7:0]  exp,
    input  logic [22:0] mantis,
    output fp_type_e    fp_type
);

    // Exponent all-zero / all-one selects the special classes
    always_comb begin
        fp_type = NORMAL;
        if (exp == '0) begin
            fp_type = (mantis == '0) ? ZERO : SUBNORMAL;
        end else if (exp == '1) begin
            fp_type = (mantis == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp_add_ctrl.sv
// Control FSM around an external adder: resolves special operands locally,
// launches the datapath for finite non-zero pairs, and aborts on timeout.
module fp_add_ctrl
    import fp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        dp_start,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    input  logic        dp_done,
    input  logic [31:0] dp_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_e           state, state_next;
    fp_type_e         type_a, type_b;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             special;
    logic [31:0]      special_val;

    type_detect u_type_a (
        .exp     (dp_a[30:23]),
        .mantis  (dp_a[22:0]),
        .fp_type (type_a)
    );

    type_detect u_type_b (
        .exp     (dp_b[30:23]),
        .mantis  (dp_b[22:0]),
        .fp_type (type_b)
    );

    assign cnt_last = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Special-case result selection from the operand classes
    always_comb begin
        special     = 1'b1;
        special_val = QNAN;
        if (type_a == NAN || type_b == NAN) begin
            special_val = QNAN;
        end else if (type_a == INF && type_b == INF) begin
            special_val = (dp_a[31] != dp_b[31]) ? QNAN : dp_a;
        end else if (type_a == INF) begin
            special_val = dp_a;
        end else if (type_b == INF) begin
            special_val = dp_b;
        end else if (type_a == ZERO && type_b == ZERO) begin
            special_val = {dp_a[31] & dp_b[31], 31'b0};
        end else if (type_a == ZERO) begin
            special_val = dp_b;
        end else if (type_b == ZERO) begin
            special_val = dp_a;
        end else begin
            special = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        dp_start   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_CLASSIFY;
            end
            ST_CLASSIFY: begin
                state_next = special ? ST_DONE : ST_START;
            end
            ST_START: begin
                dp_start   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (dp_done || cnt_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, result loading and WAIT cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a    <= '0;
            dp_b    <= '0;
            result  <= '0;
            timeout <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        dp_a <= a;
                        dp_b <= b;
                    end
                end
                ST_CLASSIFY: begin
                    if (special) begin
                        result  <= special_val;
                        timeout <= 1'b0;
                    end
                end
                ST_START: begin
                    cnt <= '0;
                end
                ST_WAIT: begin
                    // dp_done has priority over expiry on the same cycle
                    if (dp_done) begin
                        result  <= dp_result;
                        timeout <= 1'b0;
                    end else if (cnt_last) begin
                        result  <= QNAN;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fp_add_ctrl.md
FP_ADD_CTRL -- requirements
Module: fp_add_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max WAIT-state cycles before abort.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair offered
- in_ready  out  1  controller can accept
- a, b  in  32  IEEE-754 single operands
- dp_start  out  1  one-cycle launch pulse to add datapath
- dp_a, dp_b  out  32  operands presented to datapath
- dp_done  in  1  datapath result valid, one-cycle pulse
- dp_result  in  32  datapath sum
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  32  final sum
- timeout  out  1  result is a timeout abort

Function
REQ-003 SHALL implement a Moore FSM with states IDLE, CLASSIFY, START, WAIT, DONE.
REQ-004 in_ready SHALL be 1 exactly in IDLE; transfer occurs on an edge with in_valid & in_ready, capturing a and b into dp_a/dp_b and moving to CLASSIFY.
REQ-005 CLASSIFY SHALL classify both captured operands as ZERO/INF/SUBNORMAL/NORMAL/NAN (exp all-0/all-1 vs mantissa zero/nonzero).
REQ-006 Special cases resolved in CLASSIFY, loading result and going to DONE without dp_start:
- either NAN -> 32'h7FC00000
- INF + INF opposite signs -> 32'h7FC00000
- any INF otherwise -> that INF (sign preserved)
- ZERO + ZERO -> zero with sign = a[31] & b[31]
- ZERO + X -> X unmodified, X NORMAL or SUBNORMAL (either operand order).
REQ-007 NORMAL/SUBNORMAL pairs SHALL go CLASSIFY -> START -> WAIT; dp_start SHALL be 1 only in START (exactly one cycle).
REQ-008 dp_done SHALL be honoured only in WAIT; on dp_done, result <= dp_result, timeout <= 0, go DONE; dp_done in other states ignored.
REQ-009 WAIT SHALL count cycles from 0; if count reaches TIMEOUT_CYCLES-1 without dp_done, result <= 32'h7FC00000, timeout <= 1, go DONE; dp_done on the expiry cycle wins.
REQ-010 out_valid SHALL be 1 exactly in DONE; result and timeout SHALL be stable while out_valid & !out_ready.
REQ-011 DONE SHALL return to IDLE on out_ready; no new operand accepted in that same cycle.
REQ-012 Latency: special path out_valid 2 edges after accept edge; normal path out_valid 1 edge after the edge sampling dp_done.
REQ-013 dp_a/dp_b SHALL hold captured operands from accept until next accept.
REQ-014 Counter width SHALL be $clog2(TIMEOUT_CYCLES)+1; counter cleared on WAIT entry.

Reset
REQ-015 rst_n low SHALL immediately force IDLE, regardless of current state.
REQ-016 Reset values: in_ready 1, dp_start 0, dp_a 0, dp_b 0, out_valid 0, result 0, timeout 0, counter 0.
REQ-017 Reset mid-WAIT SHALL abandon the operation; later dp_done pulses are ignored.

Structure
REQ-018 Shared package fp_pkg SHALL hold type codes ZERO=3'b000, INF=3'b001, SUBNORMAL=3'b010, NORMAL=3'b011, NAN=3'b100, constant QNAN=32'h7FC00000, FSM state encoding.
REQ-019 Operand classification SHALL use two instances of existing sub-module type_detect (exp, mantis -> type).
REQ-020 Controller SHALL contain no arithmetic beyond sign logic and the timeout counter.

Verification
REQ-021 a=3F800000, b=7F800000 -> no dp_start; result 7F800000, out_valid 2 edges after accept, timeout 0.
REQ-022 a=7F800000, b=FF800000 -> 7FC00000; a=7FC00001, b=3F800000 -> 7FC00000.
REQ-023 a=80000000, b=80000000 -> 80000000; a=00000000, b=80000000 -> 00000000; a=00000000, b=00000001 -> 00000001.
REQ-024 a=3F800000, b=40000000 -> single dp_start, dp_a/dp_b match; dp_done after 5 cycles with 40400000 -> result 40400000; hold out_ready low 3 cycles, result stable, in_ready 0.
REQ-025 Normal pair, dp_done never -> after 64 WAIT cycles result 7FC00000, timeout 1; next transaction clears timeout.
REQ-026 rst_n low during WAIT -> all outputs at reset values immediately; after release in_ready 1, stray dp_done produces no out_valid.
